// File: rtl/core_load_sequencer.sv
// core_load_sequencer
// Host-side loader and run controller for a small core. While the core is held
// in reset, host beats are written into instruction or data memory registers;
// a start request then releases the core and counts its run cycles until the
// core finishes, the cycle budget expires, or the host aborts.
module core_load_sequencer #(
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic        ld_sel,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   input  logic        start,
   input  logic        abort,
   input  logic        clr,
   input  logic        Finish_Prog,
   output logic        core_rst_n,
   output logic        Instruction_Write_Enable,
   output logic [31:0] Instruction_Write,
   output logic [31:0] Instruction_Address,
   output logic [31:0] Data_write_Data,
   output logic [31:0] Data_write_Address,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   // Timeout fires when the post-increment count reaches this value.
   localparam logic [31:0] CYC_LIMIT = 32'(MAX_CYCLES - 32'd1);

   state_t      state_q, state_d;

   logic        core_rst_n_q, core_rst_n_d;
   logic        busy_q,       busy_d;
   logic        done_q,       done_d;
   logic        timeout_q,    timeout_d;
   logic        iwe_q,        iwe_d;
   logic [31:0] iw_data_q,    iw_data_d;
   logic [31:0] iw_addr_q,    iw_addr_d;
   logic [31:0] dw_data_q,    dw_data_d;
   logic [31:0] dw_addr_q,    dw_addr_d;
   logic [31:0] run_cyc_q,    run_cyc_d;

   logic        accept;
   logic [31:0] run_cyc_inc;

   // Beat acceptance and saturating run-cycle increment.
   always_comb begin
      accept      = (state_q == S_IDLE) && ld_valid;
      run_cyc_inc = (run_cyc_q == '1) ? run_cyc_q : run_cyc_q + 32'd1;
   end

   // State register; reset forces IDLE without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: load beats beat start, abort beats finish beats timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ld_valid) begin
               state_d = S_LOAD;
            end else if (start) begin
               state_d = S_RUN;
            end
         end
         S_LOAD: begin
            state_d = S_IDLE;
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (Finish_Prog) begin
               state_d = S_DONE;
            end else if (run_cyc_inc >= CYC_LIMIT) begin
               state_d = S_TIMEOUT;
            end
         end
         S_DONE, S_TIMEOUT: begin
            if (clr) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output next values: status flags are decoded from the upcoming state so
   // the registered outputs line up with the state they describe.
   always_comb begin
      core_rst_n_d = (state_d == S_RUN);
      busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      timeout_d    = (state_d == S_TIMEOUT);
      iwe_d        = accept && !ld_sel;

      iw_data_d = iw_data_q;
      iw_addr_d = iw_addr_q;
      if (accept && !ld_sel) begin
         iw_data_d = ld_data;
         iw_addr_d = ld_addr;
      end

      // The data memory writes continuously while the core is held, so these
      // only move on an accepted data beat.
      dw_data_d = dw_data_q;
      dw_addr_d = dw_addr_q;
      if (accept && ld_sel) begin
         dw_data_d = ld_data;
         dw_addr_d = ld_addr;
      end

      // Abort leaves the count untouched; finish and timeout count their cycle.
      run_cyc_d = run_cyc_q;
      if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
         run_cyc_d = '0;
      end else if ((state_q == S_RUN) && !abort) begin
         run_cyc_d = run_cyc_inc;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         iwe_q        <= 1'b0;
         iw_data_q    <= '0;
         iw_addr_q    <= '0;
         dw_data_q    <= '0;
         dw_addr_q    <= '0;
         run_cyc_q    <= '0;
      end else begin
         core_rst_n_q <= core_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         iwe_q        <= iwe_d;
         iw_data_q    <= iw_data_d;
         iw_addr_q    <= iw_addr_d;
         dw_data_q    <= dw_data_d;
         dw_addr_q    <= dw_addr_d;
         run_cyc_q    <= run_cyc_d;
      end
   end

   // Port mapping; ld_ready is the only output decoded directly from state.
   always_comb begin
      ld_ready                 = (state_q == S_IDLE);
      core_rst_n               = core_rst_n_q;
      busy                     = busy_q;
      done                     = done_q;
      timeout                  = timeout_q;
      Instruction_Write_Enable = iwe_q;
      Instruction_Write        = iw_data_q;
      Instruction_Address      = iw_addr_q;
      Data_write_Data          = dw_data_q;
      Data_write_Address       = dw_addr_q;
      run_cycles               = run_cyc_q;
   end

endmodule
